rx_char_replace: RTL and testbench
==================================

# rx_char_replace

Undoes JESD204B lane alignment character replacement on the RX datapath. It sits directly downstream of the frame/multiframe marker generator and the 8b/10b decode stage. It uses the per-octet end-of-frame and end-of-multiframe markers to restore /F/ (K28.7, 0xFC) and /A/ (K28.3, 0x7C) control characters to their data values. It also flags characters that arrive at illegal positions, which indicates lost frame alignment.

## Interface
- PARALLEL_OCTETS, 4: octets per beat (P); octet i occupies data bits [8i+7:8i], and octet 0 is earliest on the wire.
- ERR_CNT_W, 8: width of the saturating error counter.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- scr_en_i  in  1  scrambling enabled (JESD SCR=1); must be static while valid_i is active.
- valid_i  in  1  beat qualifier; all other inputs are ignored when low.
- data_i  in  8P  decoded octets.
- charisk_i  in  P  per-octet K-character flag.
- sof_i, eof_i, somf_i, eomf_i  in  P each  per-octet frame/multiframe markers, aligned with data_i.
- clr_err_i  in  1  synchronous clear of err_align_o and err_cnt_o.
- valid_o  out  1  registered valid_i.
- data_o  out  8P  restored octets.
- sof_o, eof_o, somf_o, eomf_o  out  P each  markers delayed one cycle.
- err_align_o  out  1  sticky: at least one misplaced control character seen.
- err_cnt_o  out  ERR_CNT_W  saturating count of beats containing one or more errors.

## Operation
- Per octet i in a valid beat, the block classifies the input into one of four cases:
  - F_chr: charisk_i[i] and data 0xFC.
  - A_chr: charisk_i[i] and data 0x7C.
  - other K: charisk_i[i] with any other value.
  - data: charisk_i[i] low.
- Restoration when scr_en_i=0:
  - An F_chr with eof_i[i]=1 and eomf_i[i]=0 is replaced by the previous frame's last octet.
  - An A_chr with eomf_i[i]=1 is replaced the same way.
- Restoration when scr_en_i=1: the octet passes through with its own value (0xFC or 0x7C); only the charisk flag is dropped.
- "Previous frame's last octet":
  - If a lower-index octet j<i in the same beat has eof_i[j]=1, use the restored output of the highest such j. This chain is evaluated combinationally in index order.
  - Otherwise use the held register last_q.
- last_q update: on each valid beat with any eof_i bit set, last_q takes the restored octet at the highest set eof_i index.
- Error octets (counted as an error, output data unchanged from input):
  - A_chr with eomf_i[i]=0.
  - F_chr with eof_i[i]=0.
  - F_chr with eomf_i[i]=1.
  - Any other K character.
- Error reporting:
  - Any error octet in a valid beat sets err_align_o.
  - The same beat increments err_cnt_o by 1, saturating at all-ones.
- clr_err_i:
  - Zeroes both error outputs on the next edge.
  - If an error beat coincides with clr_err_i, the clear wins: both outputs read 0.
- Data octets (charisk_i low) always pass through unchanged, including 0xFC/0x7C values.
- valid_i=0 beats:
  - valid_o=0 on the next cycle.
  - data_o and markers hold their last values.
  - last_q and the error state do not change.

## Timing
- Latency is 1 cycle: the output registers capture the restored beat on the edge after valid_i is sampled high.
- Reset (asynchronous assert, synchronous-to-clk_i deassert handled upstream) drives:
  - valid_o=0, data_o=0, all marker outputs 0.
  - last_q=0x00, err_align_o=0, err_cnt_o=0.
- Reset mid-stream discards any pending beat. If the first post-reset beat is an F_chr at eof, it is restored to 0x00.
- No backpressure; the block accepts one beat every cycle.
- scr_en_i changes are legal only while valid_i=0. Behaviour otherwise is undefined.

## Test plan
- Basic /F/ replacement:
  - Stimulus: P=4, scr_en_i=0. Beat 1 = 11 22 33 44 (eof on octet 3). Beat 2 = 55 66 77 FC with charisk[3]=1, eof[3]=1.
  - Required response: beat 2 out = 55 66 77 44, no error, 1-cycle latency.
- /A/ at multiframe end:
  - Stimulus: octet 3 = 7C K with eof and eomf set; previous frame's last octet = 9A.
  - Required response: out octet 3 = 9A, last_q=9A.
- Scrambled mode:
  - Stimulus: scr_en_i=1, FC K at eof; then 7C K at eomf.
  - Required response: outputs FC and 7C, no error.
- Misplacement:
  - Stimulus: 7C K at octet 1 with eomf_i=0, repeated on 300 consecutive beats.
  - Required response: err_align_o=1 after the first beat; err_cnt_o saturates at 255. Then assert clr_err_i -> both outputs read 0.
- Multiple frames per beat (F=2):
  - Stimulus: eof on octets 1 and 3. Input = AA BB CC FC(K), last_q=10.
  - Required response: out = AA BB CC BB; last_q becomes BB.
- Reset and idle:
  - Stimulus: assert rst_ni low mid-beat with no clock edge.
  - Required response: all outputs go 0 immediately. A valid_i=0 gap afterwards leaves last_q and err_cnt_o unchanged.

Source files
------------

// File: rtl/rx_char_replace.sv
// JESD204B RX alignment character restoration: turns /F/ and /A/ back into the
// previous frame's last octet and flags control characters at illegal positions.
module rx_char_replace #(
  parameter int unsigned PARALLEL_OCTETS = 4,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         scr_en_i,
  input  logic                         valid_i,
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
  input  logic [PARALLEL_OCTETS-1:0]   charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   sof_i,
  input  logic [PARALLEL_OCTETS-1:0]   eof_i,
  input  logic [PARALLEL_OCTETS-1:0]   somf_i,
  input  logic [PARALLEL_OCTETS-1:0]   eomf_i,
  input  logic                         clr_err_i,
  output logic                         valid_o,
  output logic [8*PARALLEL_OCTETS-1:0] data_o,
  output logic [PARALLEL_OCTETS-1:0]   sof_o,
  output logic [PARALLEL_OCTETS-1:0]   eof_o,
  output logic [PARALLEL_OCTETS-1:0]   somf_o,
  output logic [PARALLEL_OCTETS-1:0]   eomf_o,
  output logic                         err_align_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int unsigned P = PARALLEL_OCTETS;

  logic                 valid_q, valid_d;
  logic [8*P-1:0]       data_q, data_d;
  logic [P-1:0]         sof_q, sof_d, eof_q, eof_d, somf_q, somf_d, eomf_q, eomf_d;
  logic [7:0]           last_q, last_d;
  logic                 err_align_q, err_align_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [8*P-1:0] restored;
  logic [P-1:0]   err_vec;
  logic [7:0]     chain;
  logic           beat_err;

  // chain carries the most recent restored end-of-frame octet in wire order,
  // so after the loop it is exactly the next value of last_q.
  always_comb begin
    restored = data_i;
    err_vec  = '0;
    chain    = last_q;
    for (int i = 0; i < int'(P); i++) begin
      logic [7:0] oct;
      logic       is_f, is_a, repl;
      oct  = data_i[8*i +: 8];
      is_f = charisk_i[i] && (oct == 8'hFC);
      is_a = charisk_i[i] && (oct == 8'h7C);
      repl = !scr_en_i && ((is_f && eof_i[i] && !eomf_i[i]) || (is_a && eomf_i[i]));
      err_vec[i] = (is_a && !eomf_i[i]) || (is_f && (!eof_i[i] || eomf_i[i])) ||
                   (charisk_i[i] && !is_f && !is_a);
      if (repl) begin
        restored[8*i +: 8] = chain;
      end
      if (eof_i[i]) begin
        chain = restored[8*i +: 8];
      end
    end
  end

  assign beat_err = valid_i && (|err_vec);

  always_comb begin
    valid_d  = valid_i;
    data_d   = data_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    somf_d   = somf_q;
    eomf_d   = eomf_q;
    last_d   = last_q;
    if (valid_i) begin
      data_d = restored;
      sof_d  = sof_i;
      eof_d  = eof_i;
      somf_d = somf_i;
      eomf_d = eomf_i;
      last_d = chain;
    end
  end

  always_comb begin
    err_align_d = err_align_q;
    err_cnt_d   = err_cnt_q;
    if (clr_err_i) begin
      err_align_d = 1'b0;
      err_cnt_d   = '0;
    end else if (beat_err) begin
      err_align_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      sof_q       <= '0;
      eof_q       <= '0;
      somf_q      <= '0;
      eomf_q      <= '0;
      last_q      <= '0;
      err_align_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      somf_q      <= somf_d;
      eomf_q      <= eomf_d;
      last_q      <= last_d;
      err_align_q <= err_align_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign somf_o      = somf_q;
  assign eomf_o      = eomf_q;
  assign err_align_o = err_align_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_rx_char_replace.sv
// Directed bench for rx_char_replace: vector table plus hand-written
// saturation, clear and reset sequences.
module tb_rx_char_replace;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        scr_en_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [3:0]  charisk_i = '0;
  logic [3:0]  sof_i = '0, eof_i = '0, somf_i = '0, eomf_i = '0;
  logic        clr_err_i = 1'b0;
  logic        valid_o;
  logic [31:0] data_o;
  logic [3:0]  sof_o, eof_o, somf_o, eomf_o;
  logic        err_align_o;
  logic [7:0]  err_cnt_o;

  rx_char_replace #(
    .PARALLEL_OCTETS(4),
    .ERR_CNT_W      (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .scr_en_i   (scr_en_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .charisk_i  (charisk_i),
    .sof_i      (sof_i),
    .eof_i      (eof_i),
    .somf_i     (somf_i),
    .eomf_i     (eomf_i),
    .clr_err_i  (clr_err_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .sof_o      (sof_o),
    .eof_o      (eof_o),
    .somf_o     (somf_o),
    .eomf_o     (eomf_o),
    .err_align_o(err_align_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        scr;
    logic        vld;
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  eof;
    logic [3:0]  eomf;
    logic        clr;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] exp_eof = '0, exp_eomf = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic scr, input logic vld, input logic [31:0] d,
                       input logic [3:0] k, input logic [3:0] eof, input logic [3:0] eomf,
                       input logic clr);
    scr_en_i  = scr;
    valid_i   = vld;
    data_i    = d;
    charisk_i = k;
    eof_i     = eof;
    eomf_i    = eomf;
    sof_i     = ~eof;
    somf_i    = ~eomf;
    clr_err_i = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             scr  vld  data          k     eof   eomf  clr  e_vld e_data       err  cnt
    vecs[0]  = '{1'b0, 1'b1, 32'h44332211, 4'h0, 4'h8, 4'h0, 1'b0, 1'b1, 32'h44332211, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFC776655, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'h44776655, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'hFC000000, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 32'h44776655, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h9A998877, 4'h0, 4'h8, 4'h0, 1'b0, 1'b1, 32'h9A998877, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'h7C030201, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1, 32'h9A030201, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'hFC060504, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'h9A060504, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'h10000000, 4'h0, 4'h8, 4'h0, 1'b0, 1'b1, 32'h10000000, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'hFCCCBBAA, 4'h8, 4'hA, 4'h0, 1'b0, 1'b1, 32'hBBCCBBAA, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'hFC000000, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'hBB000000, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'hFCFC2211, 4'hC, 4'hC, 4'h0, 1'b0, 1'b1, 32'hBBBB2211, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 32'h7CFC0000, 4'h0, 4'h8, 4'h0, 1'b0, 1'b1, 32'h7CFC0000, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 32'hFC000001, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'h7C000001, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h7C000001, 1'b0, 8'd0};
    vecs[13] = '{1'b1, 1'b1, 32'hFC000002, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'hFC000002, 1'b0, 8'd0};
    vecs[14] = '{1'b1, 1'b1, 32'h7C000003, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1, 32'h7C000003, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h7C000003, 1'b0, 8'd0};
    vecs[16] = '{1'b0, 1'b1, 32'hFC000004, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'h7C000004, 1'b0, 8'd0};
    vecs[17] = '{1'b0, 1'b1, 32'hFC000005, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1, 32'hFC000005, 1'b1, 8'd1};
    vecs[18] = '{1'b0, 1'b1, 32'h000000BC, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 32'h000000BC, 1'b1, 8'd2};
    vecs[19] = '{1'b0, 1'b1, 32'h000000BC, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1, 32'h000000BC, 1'b0, 8'd0};
    vecs[20] = '{1'b0, 1'b0, 32'hBC00007C, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 32'h000000BC, 1'b0, 8'd0};
    vecs[21] = '{1'b0, 1'b1, 32'hFC000006, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 32'hFC000006, 1'b0, 8'd0};

    // Reset state
    #12;
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_eof", {28'b0, eof_o}, 32'h0);
    chk("rst_err", {23'b0, err_align_o, err_cnt_o}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      drive(vecs[v].scr, vecs[v].vld, vecs[v].data, vecs[v].k, vecs[v].eof, vecs[v].eomf,
            vecs[v].clr);
      if (vecs[v].vld) begin
        exp_eof  = vecs[v].eof;
        exp_eomf = vecs[v].eomf;
      end
      step();
      chk($sformatf("v%0d_valid", v), {31'b0, valid_o}, {31'b0, vecs[v].e_vld});
      chk($sformatf("v%0d_data", v), data_o, vecs[v].e_data);
      chk($sformatf("v%0d_err", v), {31'b0, err_align_o}, {31'b0, vecs[v].e_err});
      chk($sformatf("v%0d_cnt", v), {24'b0, err_cnt_o}, {24'b0, vecs[v].e_cnt});
      chk($sformatf("v%0d_mark", v), {16'b0, sof_o, eof_o, somf_o, eomf_o},
          {16'b0, ~exp_eof, exp_eof, ~exp_eomf, exp_eomf});
    end

    // Misplaced /A/ on 300 beats: counter saturates
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h00007C00, 4'h2, 4'h0, 4'h0, 1'b0);
      step();
      if (b == 0) begin
        chk("mis_first_err", {31'b0, err_align_o}, 32'h1);
        chk("mis_first_cnt", {24'b0, err_cnt_o}, 32'd1);
      end
    end
    chk("mis_data", data_o, 32'h00007C00);
    chk("mis_sat_cnt", {24'b0, err_cnt_o}, 32'd255);
    chk("mis_sat_err", {31'b0, err_align_o}, 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    chk("clr_err", {31'b0, err_align_o}, 32'h0);
    chk("clr_cnt", {24'b0, err_cnt_o}, 32'd0);

    // Load an error and a non-zero last octet, then reset asynchronously mid-beat
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h55000099, 4'h1, 4'h8, 4'h0, 1'b0);
    step();
    chk("pre_rst_cnt", {24'b0, err_cnt_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h12345678, 4'h0, 4'h8, 4'h0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid_o}, 32'h0);
    chk("async_rst_data", data_o, 32'h0);
    chk("async_rst_mark", {16'b0, sof_o, eof_o, somf_o, eomf_o}, 32'h0);
    chk("async_rst_err", {23'b0, err_align_o, err_cnt_o}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 32'hFC7CFC7C, 4'hF, 4'hF, 4'h0, 1'b0);
    step();
    chk("gap_valid", {31'b0, valid_o}, 32'h0);
    chk("gap_cnt", {24'b0, err_cnt_o}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hFC000007, 4'h8, 4'h8, 4'h0, 1'b0);
    step();
    chk("post_rst_f", data_o, 32'h00000007);
    chk("post_rst_cnt", {24'b0, err_cnt_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
